// File: rtl/poly_decompress_stream.sv
// Streams one polynomial of decompressed coefficients, LANES per beat,
// from a packed source captured at start (message decode or DV-bit decompress).
module poly_decompress_stream #(
    parameter int KYBER_Q = 3329,
    parameter int KYBER_N = 256,
    parameter int LANES   = 2,
    parameter int DV      = 4,
    parameter int LENGTH  = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    input  logic [KYBER_N*DV-1:0]     iData,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                Poly_Ad,
    output logic [LANES*LENGTH-1:0]   Poly_Data,
    output logic                      busy,
    output logic                      Function_Done
);

    localparam int DW = KYBER_N * DV;
    localparam int SW = $clog2(DW);
    // Wide enough that x*Q plus the rounding constant never wraps before the shift.
    localparam int PW = LENGTH + DV + 2;
    localparam logic [7:0] LAST_AD = 8'(KYBER_N - LANES);
    localparam logic [7:0] STEP    = 8'(LANES);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [DW-1:0]            data_q;
    logic                     mode_q;
    logic [7:0]               index_q;
    logic                     last_beat;
    wire  [LANES*LENGTH-1:0]  lane_data;

    assign last_beat = (index_q == LAST_AD);

    // State register; reset abandons any polynomial in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only matters in IDLE, last handshake ends the stream.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SEND;
            SEND: if (out_ready && last_beat) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the source on an accepted start and advance the beat index on each handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q  <= '0;
            mode_q  <= 1'b0;
            index_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        data_q  <= iData;
                        mode_q  <= mode;
                        index_q <= '0;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        index_q <= last_beat ? 8'd0 : index_q + STEP;
                    end
                end
                default: index_q <= '0;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0]        coef_idx;
        logic [SW-1:0]     dec_pos;
        logic [SW-1:0]     msg_pos;
        logic [PW-1:0]     dec_round;
        logic [PW-1:0]     msg_round;
        logic [LENGTH-1:0] coef;

        // Per-lane coefficient: pick the source field, scale by Q, round, then shift by d.
        always_comb begin
            coef_idx  = index_q + 8'(i);
            dec_pos   = SW'(coef_idx) * SW'(DV);
            msg_pos   = SW'(coef_idx);
            dec_round = PW'(data_q[dec_pos +: DV]) * PW'(KYBER_Q) + (PW'(1) << (DV - 1));
            msg_round = (data_q[msg_pos] ? PW'(KYBER_Q) : PW'(0)) + PW'(1);
            if (mode_q) begin
                coef = LENGTH'(dec_round >> DV);
            end else begin
                coef = LENGTH'(msg_round >> 1);
            end
        end

        assign lane_data[i*LENGTH +: LENGTH] = coef;
    end

    // Outputs are zero outside SEND so reset and DONE present a clean bus.
    always_comb begin
        out_valid     = 1'b0;
        busy          = 1'b0;
        Function_Done = 1'b0;
        Poly_Ad       = '0;
        Poly_Data     = '0;
        case (state)
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                Poly_Ad   = index_q;
                Poly_Data = lane_data;
            end
            DONE: Function_Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_poly_decompress_stream.sv
// Directed bench for poly_decompress_stream: vector table of whole polynomials
// plus hand-written backpressure, start-while-busy and mid-stream reset sequences.
module tb_poly_decompress_stream;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int LANES   = 2;
    localparam int DV      = 4;
    localparam int LENGTH  = 12;
    localparam int DW      = KYBER_N * DV;
    localparam int BEATS   = KYBER_N / LANES;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic                     mode = 1'b0;
    logic                     out_ready = 1'b0;
    logic [DW-1:0]            iData = '0;
    logic                     out_valid;
    logic                     busy;
    logic                     Function_Done;
    logic [7:0]               Poly_Ad;
    logic [LANES*LENGTH-1:0]  Poly_Data;

    int checks = 0;
    int errors = 0;

    poly_decompress_stream #(
        .KYBER_Q (KYBER_Q),
        .KYBER_N (KYBER_N),
        .LANES   (LANES),
        .DV      (DV),
        .LENGTH  (LENGTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .iData         (iData),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .Poly_Ad       (Poly_Ad),
        .Poly_Data     (Poly_Data),
        .busy          (busy),
        .Function_Done (Function_Done)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ramp;
        logic        mode;
        logic [DW-1:0] data;
        int          ad_a;
        logic [11:0] a0;
        logic [11:0] a1;
        int          ad_b;
        logic [11:0] b0;
        logic [11:0] b1;
        logic [11:0] fill;
    } vec_t;

    vec_t vecs[7];
    vec_t ramp_vec;

    function automatic vec_t mkVec(string name, logic ramp, logic m, logic [DW-1:0] d,
                                   int ad_a, logic [11:0] a0, logic [11:0] a1,
                                   int ad_b, logic [11:0] b0, logic [11:0] b1,
                                   logic [11:0] fill);
        vec_t v;
        v.name = name;
        v.ramp = ramp;
        v.mode = m;
        v.data = d;
        v.ad_a = ad_a;
        v.a0   = a0;
        v.a1   = a1;
        v.ad_b = ad_b;
        v.b0   = b0;
        v.b1   = b1;
        v.fill = fill;
        return v;
    endfunction

    // (x*3329 + 8) >> 4 for x = 0..15, worked by hand.
    function automatic logic [11:0] rampCoef(int j);
        case (j & 15)
            0:  return 12'd0;
            1:  return 12'd208;
            2:  return 12'd416;
            3:  return 12'd624;
            4:  return 12'd832;
            5:  return 12'd1040;
            6:  return 12'd1248;
            7:  return 12'd1456;
            8:  return 12'd1665;
            9:  return 12'd1873;
            10: return 12'd2081;
            11: return 12'd2289;
            12: return 12'd2497;
            13: return 12'd2705;
            14: return 12'd2913;
            default: return 12'd3121;
        endcase
    endfunction

    function automatic logic [23:0] expLanes(vec_t v, int ad);
        if (v.ramp) return {rampCoef(ad + 1), rampCoef(ad)};
        if (ad == v.ad_a) return {v.a1, v.a0};
        if (ad == v.ad_b) return {v.b1, v.b0};
        return {v.fill, v.fill};
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkIdle(string name);
        checkOutput({name, " flags"}, {29'd0, out_valid, busy, Function_Done}, 32'd0);
        checkOutput({name, " ad"}, 32'(Poly_Ad), 32'd0);
        checkOutput({name, " data"}, 32'(Poly_Data), 32'd0);
    endtask

    // Called on a negedge in IDLE; returns on the negedge where beat 0 is visible.
    task automatic applyStimulus(logic m, logic [DW-1:0] d);
        mode  = m;
        iData = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes one full polynomial, optionally stalling or re-pulsing start at a given beat.
    task automatic runStream(vec_t v, int stall_ad, int stall_n, int restart_ad);
        logic [23:0] exp;
        out_ready = 1'b1;
        for (int beat = 0; beat < BEATS; beat++) begin
            int ad;
            ad  = beat * LANES;
            exp = expLanes(v, ad);
            checkOutput($sformatf("%s flags b%0d", v.name, beat),
                        {29'd0, out_valid, busy, Function_Done}, 32'd6);
            checkOutput($sformatf("%s ad b%0d", v.name, beat), 32'(Poly_Ad), 32'(ad));
            checkOutput($sformatf("%s data b%0d", v.name, beat), 32'(Poly_Data), 32'(exp));
            if (ad == stall_ad) begin
                out_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    @(negedge clk);
                    checkOutput($sformatf("%s stall valid %0d", v.name, k), 32'(out_valid), 32'd1);
                    checkOutput($sformatf("%s stall ad %0d", v.name, k), 32'(Poly_Ad), 32'(ad));
                    checkOutput($sformatf("%s stall data %0d", v.name, k), 32'(Poly_Data), 32'(exp));
                end
                out_ready = 1'b1;
            end
            if (ad == restart_ad) begin
                start = 1'b1;
                mode  = ~v.mode;
                iData = ~v.data;
            end
            @(negedge clk);
            start = 1'b0;
        end
        checkOutput({v.name, " done flags"}, {29'd0, out_valid, busy, Function_Done}, 32'd1);
        checkOutput({v.name, " done ad"}, 32'(Poly_Ad), 32'd0);
        checkOutput({v.name, " done data"}, 32'(Poly_Data), 32'd0);
        @(negedge clk);
        checkIdle({v.name, " after done"});
    endtask

    initial begin
        vecs[0] = mkVec("msg_ones", 1'b0, 1'b0, {DW{1'b1}},
                        0, 12'd1665, 12'd1665, 254, 12'd1665, 12'd1665, 12'd1665);
        vecs[1] = mkVec("msg_order", 1'b0, 1'b0, DW'(16'h0102),
                        0, 12'd0, 12'd1665, 8, 12'd1665, 12'd0, 12'd0);
        vecs[2] = mkVec("dec_f1", 1'b0, 1'b1, DW'(8'hF1),
                        0, 12'd208, 12'd3121, 2, 12'd0, 12'd0, 12'd0);
        vecs[3] = mkVec("dec_max", 1'b0, 1'b1, {DW{1'b1}},
                        0, 12'd3121, 12'd3121, 254, 12'd3121, 12'd3121, 12'd3121);
        vecs[4] = mkVec("dec_top", 1'b0, 1'b1, {4'h8, {(DW-4){1'b0}}},
                        0, 12'd0, 12'd0, 254, 12'd0, 12'd1665, 12'd0);
        vecs[5] = mkVec("dec_mid", 1'b0, 1'b1, DW'(16'h2700),
                        2, 12'd1456, 12'd416, 0, 12'd0, 12'd0, 12'd0);
        vecs[6] = mkVec("msg_upper", 1'b0, 1'b0, {{(DW-KYBER_N){1'b1}}, {KYBER_N{1'b0}}},
                        0, 12'd0, 12'd0, 254, 12'd0, 12'd0, 12'd0);
        ramp_vec = mkVec("ramp", 1'b1, 1'b1, {(DW/64){64'hFEDCBA9876543210}},
                         -1, 12'd0, 12'd0, -1, 12'd0, 12'd0, 12'd0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle("post reset");

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].mode, vecs[v].data);
            runStream(vecs[v], -1, 0, -1);
        end

        $display("[TB] backpressure at Poly_Ad=10");
        applyStimulus(ramp_vec.mode, ramp_vec.data);
        runStream(ramp_vec, 10, 3, -1);

        $display("[TB] start pulsed while busy at Poly_Ad=20");
        applyStimulus(ramp_vec.mode, ramp_vec.data);
        runStream(ramp_vec, -1, 0, 20);

        $display("[TB] reset at Poly_Ad=40");
        applyStimulus(1'b0, {DW{1'b1}});
        out_ready = 1'b1;
        for (int beat = 0; beat < 20; beat++) begin
            @(negedge clk);
        end
        checkOutput("pre-reset ad", 32'(Poly_Ad), 32'd40);
        checkOutput("pre-reset data", 32'(Poly_Data), {8'd0, 12'd1665, 12'd1665});
        rst_n = 1'b0;
        @(negedge clk);
        checkIdle("mid reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle("after mid reset");
        applyStimulus(vecs[2].mode, vecs[2].data);
        runStream(vecs[2], -1, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
